// File: rtl/_arb_mux.sv
// _arb_mux -- registered, handshaked N-to-1 multiplexer with built-in arbitration.
//
// Several producers present valid/data on their own channel; one is granted
// per cycle (round-robin or fixed lowest-index priority). The granted word is
// captured into a single output register along with the index of its source.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   [n-1:0]   per-channel request
//   in         [w-1:0] x n per-channel data
//   in_ready   [n-1:0]   per-channel accept (combinational, one-hot or zero)
//   out_valid            output register holds a word
//   out        [w-1:0]   registered data
//   out_sel    [s-1:0]   index of the channel that sourced out
//   out_ready            consumer accepts out this cycle

package constants;
    localparam int WORD_LENGTH = 32;
endpackage

package macros;
    // Ceiling log2, never less than 1 so a select field always has a bit.
    function automatic int log_2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

module _arb_mux #(
    parameter  int n  = 4,
    parameter  int w  = constants::WORD_LENGTH,
    parameter  bit rr = 1'b1,
    localparam int s  = macros::log_2(n)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in_valid,
    input  logic [w-1:0] in [n],
    output logic [n-1:0] in_ready,
    output logic         out_valid,
    output logic [w-1:0] out,
    output logic [s-1:0] out_sel,
    input  logic         out_ready
);

    logic [s-1:0] ptr;        // round-robin search start; unused when rr = 0
    logic [s-1:0] grant;
    logic         any_valid;
    logic         load;
    logic [n-1:0] high_req;   // requests at or above ptr
    logic [n-1:0] pick_vec;

    assign any_valid = |in_valid;
    assign load      = !out_valid || out_ready;

    // Round-robin as a two-pass priority encode: first look at requests at or
    // above ptr; if none, fall back to all requests, which is the wrap-around.
    // With rr = 0 every request counts as "high", giving plain lowest-index.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        high_req = '0;
        for (int i = 0; i < n; i++) begin
            high_req[i] = in_valid[i] && (!rr || (s'(i) >= ptr));
        end
        pick_vec = (|high_req) ? high_req : in_valid;
        grant    = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (pick_vec[i]) grant = s'(i);
        end
    end

    // Ready depends only on valids and output state, never on data.
    always_comb begin
        in_ready = '0;
        if (!rst && load && any_valid) in_ready[grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    // NOTE: the data register is a plain flop, not a memory, so it is cheap to
    // reset and gives a defined out value after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_valid) begin
                out       <= in[grant];
                out_sel   <= grant;
                out_valid <= 1'b1;
                // Explicit wrap keeps ptr below n for non-power-of-two n.
                if (rr) ptr <= (grant == s'(n - 1)) ? '0 : grant + 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb__arb_mux.sv
// Self-checking bench for _arb_mux. Three instances run side by side on shared
// clock/reset: n=4 round-robin, n=3 round-robin, n=4 fixed priority.
module tb__arb_mux;

    localparam int NI = 3;
    localparam int CN  [NI] = '{4, 3, 4};
    localparam bit CRR [NI] = '{1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vin  [NI];
    logic [7:0] din  [NI][4];
    logic       ordy [NI];
    logic [7:0] d1   [3];

    logic [3:0] rdy0, rdy2;
    logic [2:0] rdy1;
    logic       ov0, ov1, ov2;
    logic [7:0] o0, o1, o2;
    logic [1:0] s0, s1, s2;

    int total = 0;
    int bad   = 0;

    // Reference model state, per instance
    bit         m_ov    [NI];
    logic [7:0] m_out   [NI];
    int         m_sel   [NI];
    int         m_start [NI];

    always #5 clk = ~clk;

    always_comb for (int c = 0; c < 3; c++) d1[c] = din[1][c];

    _arb_mux #(.n(4), .w(8), .rr(1'b1)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(vin[0]), .in(din[0]), .in_ready(rdy0),
        .out_valid(ov0), .out(o0), .out_sel(s0), .out_ready(ordy[0]));

    _arb_mux #(.n(3), .w(8), .rr(1'b1)) u_rr3 (
        .clk(clk), .rst(rst), .in_valid(vin[1][2:0]), .in(d1), .in_ready(rdy1),
        .out_valid(ov1), .out(o1), .out_sel(s1), .out_ready(ordy[1]));

    _arb_mux #(.n(4), .w(8), .rr(1'b0)) u_fp4 (
        .clk(clk), .rst(rst), .in_valid(vin[2]), .in(din[2]), .in_ready(rdy2),
        .out_valid(ov2), .out(o2), .out_sel(s2), .out_ready(ordy[2]));

    task automatic check(input string tag, input int i, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_rdy(input int i);
        case (i)
            0:       return 32'(rdy0);
            1:       return 32'(rdy1);
            default: return 32'(rdy2);
        endcase
    endfunction

    function automatic logic [31:0] get_ov(input int i);
        case (i)
            0:       return 32'(ov0);
            1:       return 32'(ov1);
            default: return 32'(ov2);
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int i);
        case (i)
            0:       return 32'(o0);
            1:       return 32'(o1);
            default: return 32'(o2);
        endcase
    endfunction

    function automatic logic [31:0] get_sel(input int i);
        case (i)
            0:       return 32'(s0);
            1:       return 32'(s1);
            default: return 32'(s2);
        endcase
    endfunction

    // First requesting channel found walking upward from 'start', modulo n.
    function automatic int pick(input int n, input int mask, input int start);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (start + k) % n;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_ov[i] = 1'b0; m_out[i] = '0; m_sel[i] = 0; m_start[i] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            check({tag, "_ov"},  i, get_ov(i),  32'(m_ov[i]));
            check({tag, "_out"}, i, get_out(i), 32'(m_out[i]));
            check({tag, "_sel"}, i, get_sel(i), 32'(m_sel[i]));
        end
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        int g  [NI];
        bit ld [NI];
        #1;
        for (int i = 0; i < NI; i++) begin
            int mask;
            mask  = int'(vin[i]) & ((1 << CN[i]) - 1);
            g[i]  = pick(CN[i], mask, CRR[i] ? m_start[i] : 0);
            ld[i] = !m_ov[i] || ordy[i];
            check("in_ready", i, get_rdy(i),
                  (ld[i] && g[i] >= 0) ? 32'(1 << g[i]) : 32'd0);
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (ld[i]) begin
                if (g[i] >= 0) begin
                    m_out[i]   = din[i][g[i]];
                    m_sel[i]   = g[i];
                    m_ov[i]    = 1'b1;
                    m_start[i] = (g[i] + 1) % CN[i];
                end else begin
                    m_ov[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check_outputs("cyc");
        for (int i = 0; i < NI; i++) begin
            check("sel_range", i, 32'(get_sel(i) < CN[i]), 32'd1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        rst = 1'b0;
    endtask

    task automatic set_valid(input logic [3:0] v);
        for (int i = 0; i < NI; i++) vin[i] = v;
    endtask

    task automatic set_ready(input logic r);
        for (int i = 0; i < NI; i++) ordy[i] = r;
    endtask

    initial begin
        logic [1:0] held_sel;
        logic [7:0] held_out;

        // Reset state at time zero, ready forced low while rst is high
        rst = 1'b1;
        set_ready(1'b1);
        set_valid(4'h0);
        for (int i = 0; i < NI; i++)
            for (int c = 0; c < 4; c++) din[i][c] = 8'hA0 + 8'(c);
        model_reset();
        #1;
        check_outputs("init");
        set_valid(4'hF);
        #1;
        for (int i = 0; i < NI; i++) check("rdy_in_rst", i, get_rdy(i), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all channels valid: 0,1,2,3,0,... with no bubbles
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_seq_sel", 0, 32'(s0), 32'(k % 4));
            check("rr_seq_out", 0, 32'(o0), 32'(8'hA0 + 8'(k % 4)));
            check("rr_seq_ov",  0, 32'(ov0), 32'd1);
            check("fp_seq_sel", 2, 32'(s2), 32'd0);
        end

        // Asynchronous reset mid-cycle while out_valid is high
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        for (int i = 0; i < NI; i++) check("rdy_async_rst", i, get_rdy(i), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("first_grant", 0, 32'(s0), 32'd0);

        // Backpressure with channels 1 and 2 valid
        set_valid(4'b0110);
        cycle();
        held_sel = s0;
        held_out = o0;
        set_ready(1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_hold_sel", 0, 32'(s0), 32'(held_sel));
            check("bp_hold_out", 0, 32'(o0), 32'(held_out));
        end
        set_ready(1'b1);
        cycle();
        cycle();

        // Wrap with n=3: move ptr to 2, then channels 0 and 2 valid
        do_reset();
        set_valid(4'b0010);
        cycle();
        set_valid(4'b0101);
        cycle();
        check("wrap_grant2", 1, 32'(s1), 32'd2);
        cycle();
        check("wrap_grant0", 1, 32'(s1), 32'd0);

        // Fixed priority: channels 1 and 3 valid, then only 3
        set_valid(4'b1010);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("fp_low_wins", 2, 32'(s2), 32'd1);
        end
        set_valid(4'b1000);
        cycle();
        check("fp_after_drop", 2, 32'(s2), 32'd3);

        // Idle drain: one word from channel 2, then nothing
        set_valid(4'b0000);
        cycle();
        for (int i = 0; i < NI; i++) din[i][2] = 8'h5C;
        set_valid(4'b0100);
        cycle();
        check("drain_ov1", 0, 32'(ov0), 32'd1);
        set_valid(4'b0000);
        cycle();
        check("drain_ov0",  0, 32'(ov0), 32'd0);
        check("drain_hold", 0, 32'(o0),  32'h5C);
        cycle();

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NI; i++) begin
                vin[i]  = 4'($urandom);
                ordy[i] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < 4; c++) din[i][c] = 8'($urandom);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always ends by itself
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/_arb_mux.md
# _arb_mux

Registered, handshaked N-to-1 multiplexer with built-in arbitration. Replaces externally driven select lines with valid/ready channels and a round-robin or fixed-priority arbiter. Drives one output word register, and reports which channel sourced that word. Sits wherever several producers share one consumer: register-file write-back, bus masters onto the memory port, and similar points.

## Interface

- `n`, default 4: number of input channels; n >= 2; need not be a power of two.
- `w`, default `constants::WORD_LENGTH`: data width in bits.
- `rr`, default 1: arbitration mode. 1 = round-robin; 0 = fixed priority, lowest index wins.
- `s` (localparam) = `macros::log_2(n)`: select width.

Ports:

- `clk`, input, 1: clock. Single clock domain; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, [n-1:0]: per-channel request.
- `in`, input, [w-1:0] x [n-1:0] (unpacked array): per-channel data.
- `in_ready`, output, [n-1:0]: per-channel accept. Combinational; one-hot or zero.
- `out_valid`, output, 1: output register holds a word.
- `out`, output, [w-1:0]: registered data.
- `out_sel`, output, [s-1:0]: index of the channel that sourced `out`.
- `out_ready`, input, 1: consumer accepts `out` this cycle.

## Operation

- `load = !out_valid || out_ready`. The output register can take a new word this cycle.
- Grant `g`, when `in_valid != 0`:
  - rr=1: first set bit of `in_valid` scanning upward from pointer `ptr`, wrapping modulo n.
  - rr=0: lowest set index.
- `in_ready[g] = load && (in_valid != 0)`. All other `in_ready` bits are 0. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On the clock edge, if `load` is true:
  - If some channel is valid: `out <= in[g]`, `out_sel <= g`, `out_valid <= 1`. For rr=1 also `ptr <= (g == n-1) ? 0 : g+1`; explicit wrap, so non-power-of-two n is handled.
  - If no channel is valid: `out_valid <= 0`. `out` and `out_sel` hold their values. `ptr` holds.
- If `load` is false: `out`, `out_sel`, `out_valid` and `ptr` all hold. The output is stable under backpressure.
- rr=0: `ptr` is not used and may be optimised away. Starvation of high-index channels is permitted.
- `out_sel` never takes a value >= n.
- `in_ready` must not depend on `in` data. It may depend on `in_valid`, which is a combinational valid-to-ready path (documented).
- Reset, asynchronous, any time including mid-transfer:
  - `out_valid = 0`, `out = 0`, `out_sel = 0`, `ptr = 0`.
  - `in_ready` is forced to 0 while `rst` is high.
  - A word held in the output register at reset is dropped.

## Timing

- Latency is 1 cycle: a word accepted at edge k appears on `out`/`out_valid` after edge k.
- Throughput is 1 word per cycle when `out_ready` is held high. There are no bubbles between back-to-back grants.
- Simultaneous consume and load is allowed: `out_valid && out_ready` in the same cycle as a new grant loads the new word at that edge.
- Pointer update is visible to arbitration in the cycle after the grant.
- Round-robin fairness: with all n channels continuously valid and `out_ready = 1`, grants cycle 0, 1, …, n-1, 0, … with each channel served once every n cycles.
- After `rst` deasserts, the first grant can occur in the first cycle. Output is first valid one cycle later.

## Test plan

- Reset, with n=4, w=8, `rst` pulsed asynchronously mid-cycle while `out_valid = 1` → `out_valid`, `out` and `out_sel` go to 0 immediately without waiting for a clock edge, `in_ready = 0` during reset, and the first grant after release goes to channel 0.
- Round-robin with all valid: rr=1, n=4, `in[i] = 8'hA0 + i`, all `in_valid = 1`, `out_ready = 1` for 8 cycles → `out_sel` sequence 0,1,2,3,0,1,2,3 and `out` = A0,A1,A2,A3,A0,…, with `out_valid` continuously 1.
- Backpressure: `out_ready = 0` for 3 cycles while channels 1 and 2 are valid → `out` and `out_sel` hold their first-granted values, `in_ready = 0`, `ptr` unchanged; raising `out_ready` resumes with the correct next grant.
- Wrap with non-power-of-two n: n=3, `ptr` at 2, only channels 0 and 2 valid → grant 2, then `ptr` wraps to 0 and the next grant is 0; `out_sel` never reads 3.
- Fixed priority: rr=0, channels 1 and 3 continuously valid → `out_sel` is always 1; channel 3 is granted only after `in_valid[1]` drops.
- Idle drain: a single word from channel 2 followed by no valids, with `out_ready = 1` → `out_valid` is high for exactly 1 cycle, then 0, and `out` holds its last value.
